// File: rtl/rr_priority_arbiter.sv
// Registered N-port arbiter: round-robin or fixed priority, optional grant locking
// released by request drop or acknowledge, one-hot plus binary grant outputs.
module rr_priority_arbiter #(
    parameter int unsigned PORTS                 = 4,
    parameter int unsigned ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int unsigned ARB_BLOCK             = 1,
    parameter int unsigned ARB_BLOCK_ACK         = 1,
    parameter int unsigned ARB_LSB_HIGH_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int unsigned W  = $clog2(PORTS);
    localparam int unsigned P2 = 1 << W;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] mask_next;
    logic [PORTS-1:0] masked;
    logic [PORTS-1:0] grant_next;
    logic             grant_valid_next;
    logic [W-1:0]     grant_encoded_next;
    logic [W:0]       win;
    logic             ack_hit;
    logic             req_hit;
    logic             arbitrate;

    // Fixed-priority select as a log2 tree of 2-input valid/encode stages; returns {valid, index}.
    function automatic logic [W:0] sel(input logic [PORTS-1:0] v);
        logic [P2-1:0] vp;
        logic          vld [P2];
        logic [W-1:0]  enc [P2];
        logic          take_a;
        vp = P2'(v);
        for (int unsigned k = 0; k < P2; k++) begin
            vld[k] = vp[k];
            enc[k] = W'(k);
        end
        // Each level folds pairs in place; node k only reads 2k and 2k+1, which are never behind k.
        for (int unsigned n = P2; n > 1; n = n >> 1) begin
            for (int unsigned k = 0; k < n / 2; k++) begin
                if (ARB_LSB_HIGH_PRIORITY != 0) take_a = vld[2*k];
                else                            take_a = !vld[2*k+1];
                if (take_a) begin
                    vld[k] = vld[2*k];
                    enc[k] = enc[2*k];
                end else begin
                    vld[k] = vld[2*k+1];
                    enc[k] = enc[2*k+1];
                end
            end
        end
        return {vld[0], enc[0]};
    endfunction

    // Rotation mask after granting idx: ports that come after idx in priority order.
    function automatic logic [PORTS-1:0] mask_after(input logic [W-1:0] idx);
        logic [PORTS-1:0] m;
        for (int unsigned b = 0; b < PORTS; b++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) m[b] = (b > 32'(idx));
            else                            m[b] = (b < 32'(idx));
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= '1;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
        end else begin
            state         <= state_next;
            mask          <= mask_next;
            grant         <= grant_next;
            grant_valid   <= grant_valid_next;
            grant_encoded <= grant_encoded_next;
        end
    end

    always_comb begin
        state_next         = state;
        mask_next          = mask;
        grant_next         = grant;
        grant_valid_next   = grant_valid;
        grant_encoded_next = grant_encoded;

        masked = request & mask;
        if (ARB_TYPE_ROUND_ROBIN != 0 && masked != '0) win = sel(masked);
        else                                           win = sel(request);

        ack_hit = (grant & acknowledge) != '0;
        req_hit = (grant & request) != '0;

        // A held grant is only released by its own port's ack or request drop.
        if (ARB_BLOCK == 0)            arbitrate = 1'b1;
        else if (state == IDLE)        arbitrate = 1'b1;
        else if (ARB_BLOCK_ACK != 0)   arbitrate = ack_hit;
        else                           arbitrate = !req_hit;

        if (arbitrate) begin
            if (win[W]) begin
                grant_next         = PORTS'(1) << win[W-1:0];
                grant_valid_next   = 1'b1;
                grant_encoded_next = win[W-1:0];
                state_next         = LOCKED;
                if (ARB_TYPE_ROUND_ROBIN != 0) mask_next = mask_after(win[W-1:0]);
            end else begin
                grant_next         = '0;
                grant_valid_next   = 1'b0;
                grant_encoded_next = '0;
                state_next         = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter across round-robin, fixed, locking and
// non-power-of-two configurations sharing one clock and reset.
module tb_rr_priority_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [3:0] zero4;
    logic [3:0] req_rr, g_rr, req_rl, g_rl, req_fp, g_fp;
    logic [3:0] req_ak, ack_ak, g_ak, req_nk, g_nk;
    logic [1:0] e_rr, e_rl, e_fp, e_ak, e_nk;
    logic       v_rr, v_rl, v_fp, v_ak, v_nk;
    logic [4:0] req_p5, ack_p5, g_p5;
    logic [2:0] e_p5;
    logic       v_p5;

    rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
        .ARB_LSB_HIGH_PRIORITY(0)) u_rr (.clk(clk), .rst(rst), .request(req_rr),
        .acknowledge(zero4), .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

    rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
        .ARB_LSB_HIGH_PRIORITY(1)) u_rl (.clk(clk), .rst(rst), .request(req_rl),
        .acknowledge(zero4), .grant(g_rl), .grant_valid(v_rl), .grant_encoded(e_rl));

    rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
        .ARB_LSB_HIGH_PRIORITY(0)) u_fp (.clk(clk), .rst(rst), .request(req_fp),
        .acknowledge(zero4), .grant(g_fp), .grant_valid(v_fp), .grant_encoded(e_fp));

    rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
        .ARB_LSB_HIGH_PRIORITY(0)) u_ak (.clk(clk), .rst(rst), .request(req_ak),
        .acknowledge(ack_ak), .grant(g_ak), .grant_valid(v_ak), .grant_encoded(e_ak));

    rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
        .ARB_LSB_HIGH_PRIORITY(0)) u_nk (.clk(clk), .rst(rst), .request(req_nk),
        .acknowledge(zero4), .grant(g_nk), .grant_valid(v_nk), .grant_encoded(e_nk));

    rr_priority_arbiter #(.PORTS(5)) u_p5 (.clk(clk), .rst(rst), .request(req_p5),
        .acknowledge(ack_p5), .grant(g_p5), .grant_valid(v_p5), .grant_encoded(e_p5));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req_rr = 4'b1111; req_rl = 4'b1111; req_fp = 4'b1111;
        req_ak = 4'b1111; req_nk = 4'b1111; req_p5 = 5'b11111;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({g_rr, v_rr, e_rr} !== 7'd0) begin errors++;
                $display("FAIL reset_rr cyc=%0d got g=%b v=%b e=%0d want 0", c, g_rr, v_rr, e_rr); end
            checks++; if ({g_rl, v_rl, e_rl} !== 7'd0) begin errors++;
                $display("FAIL reset_rl cyc=%0d got g=%b v=%b e=%0d want 0", c, g_rl, v_rl, e_rl); end
            checks++; if ({g_fp, v_fp, e_fp} !== 7'd0) begin errors++;
                $display("FAIL reset_fp cyc=%0d got g=%b v=%b e=%0d want 0", c, g_fp, v_fp, e_fp); end
            checks++; if ({g_ak, v_ak, e_ak} !== 7'd0) begin errors++;
                $display("FAIL reset_ak cyc=%0d got g=%b v=%b e=%0d want 0", c, g_ak, v_ak, e_ak); end
            checks++; if ({g_nk, v_nk, e_nk} !== 7'd0) begin errors++;
                $display("FAIL reset_nk cyc=%0d got g=%b v=%b e=%0d want 0", c, g_nk, v_nk, e_nk); end
            checks++; if ({g_p5, v_p5, e_p5} !== 9'd0) begin errors++;
                $display("FAIL reset_p5 cyc=%0d got g=%b v=%b e=%0d want 0", c, g_p5, v_p5, e_p5); end
        end
        rst = 1'b0;
        req_rr = '0; req_rl = '0; req_fp = '0; req_ak = '0; req_nk = '0; req_p5 = '0;
        step();
    endtask

    task automatic test_round_robin;
        int exp_m [5] = '{3, 2, 1, 0, 3};
        int exp_l [5] = '{0, 1, 2, 3, 0};
        logic [3:0] gm, gl;
        do_reset();
        req_rr = 4'b1111;
        req_rl = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            gm = 4'b0001 << exp_m[i];
            gl = 4'b0001 << exp_l[i];
            checks++; if (g_rr !== gm || e_rr !== 2'(exp_m[i]) || v_rr !== 1'b1) begin errors++;
                $display("FAIL rr_msb step=%0d got g=%b e=%0d v=%b want g=%b e=%0d v=1",
                         i, g_rr, e_rr, v_rr, gm, exp_m[i]); end
            checks++; if (g_rl !== gl || e_rl !== 2'(exp_l[i]) || v_rl !== 1'b1) begin errors++;
                $display("FAIL rr_lsb step=%0d got g=%b e=%0d v=%b want g=%b e=%0d v=1",
                         i, g_rl, e_rl, v_rl, gl, exp_l[i]); end
        end
        req_rr = '0;
        req_rl = '0;
        step();
        checks++; if (v_rr !== 1'b0 || g_rr !== 4'b0000 || e_rr !== 2'd0) begin errors++;
            $display("FAIL rr_idle got g=%b v=%b e=%0d want g=0000 v=0 e=0", g_rr, v_rr, e_rr); end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        req_fp = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (g_fp !== 4'b0100 || e_fp !== 2'd2) begin errors++;
                $display("FAIL fixed_hold cyc=%0d got g=%b e=%0d want g=0100 e=2", i, g_fp, e_fp); end
        end
        req_fp = 4'b0010;
        step();
        checks++; if (g_fp !== 4'b0010 || e_fp !== 2'd1) begin errors++;
            $display("FAIL fixed_drop got g=%b e=%0d want g=0010 e=1", g_fp, e_fp); end
        req_fp = 4'b0000;
        step();
        checks++; if (g_fp !== 4'b0000 || v_fp !== 1'b0) begin errors++;
            $display("FAIL fixed_idle got g=%b v=%b want g=0000 v=0", g_fp, v_fp); end
    endtask

    task automatic test_block_ack;
        do_reset();
        ack_ak = 4'b0000;
        req_ak = 4'b1001;
        step();
        checks++; if (g_ak !== 4'b1000 || e_ak !== 2'd3 || v_ak !== 1'b1) begin errors++;
            $display("FAIL ack_first got g=%b e=%0d v=%b want g=1000 e=3 v=1", g_ak, e_ak, v_ak); end
        req_ak = 4'b0010;
        step();
        checks++; if (g_ak !== 4'b1000) begin errors++;
            $display("FAIL ack_hold_nodrop got g=%b want 1000", g_ak); end
        ack_ak = 4'b0001;
        step();
        checks++; if (g_ak !== 4'b1000) begin errors++;
            $display("FAIL ack_wrong_port got g=%b want 1000", g_ak); end
        ack_ak = 4'b1000;
        step();
        checks++; if (g_ak !== 4'b0010 || e_ak !== 2'd1 || v_ak !== 1'b1) begin errors++;
            $display("FAIL ack_release got g=%b e=%0d v=%b want g=0010 e=1 v=1", g_ak, e_ak, v_ak); end
        ack_ak = 4'b0000;
        req_ak = 4'b0000;
        step();
        checks++; if (g_ak !== 4'b0010) begin errors++;
            $display("FAIL ack_hold_noreq got g=%b want 0010", g_ak); end
        ack_ak = 4'b0010;
        step();
        checks++; if (g_ak !== 4'b0000 || v_ak !== 1'b0 || e_ak !== 2'd0) begin errors++;
            $display("FAIL ack_to_idle got g=%b v=%b e=%0d want g=0000 v=0 e=0", g_ak, v_ak, e_ak); end
        ack_ak = 4'b1111;
        step();
        checks++; if (g_ak !== 4'b0000 || v_ak !== 1'b0) begin errors++;
            $display("FAIL ack_while_idle got g=%b v=%b want g=0000 v=0", g_ak, v_ak); end
        ack_ak = 4'b0000;
    endtask

    task automatic test_block_noack;
        do_reset();
        req_nk = 4'b0100;
        step();
        checks++; if (g_nk !== 4'b0100 || e_nk !== 2'd2) begin errors++;
            $display("FAIL noack_first got g=%b e=%0d want g=0100 e=2", g_nk, e_nk); end
        req_nk = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (g_nk !== 4'b0100) begin errors++;
                $display("FAIL noack_hold cyc=%0d got g=%b want 0100", i, g_nk); end
        end
        req_nk = 4'b0001;
        step();
        checks++; if (g_nk !== 4'b0001 || e_nk !== 2'd0 || v_nk !== 1'b1) begin errors++;
            $display("FAIL noack_release got g=%b e=%0d v=%b want g=0001 e=0 v=1", g_nk, e_nk, v_nk); end
        req_nk = 4'b0000;
        step();
        checks++; if (v_nk !== 1'b0 || g_nk !== 4'b0000 || e_nk !== 2'd0) begin errors++;
            $display("FAIL noack_idle got g=%b v=%b e=%0d want g=0000 v=0 e=0", g_nk, v_nk, e_nk); end
    endtask

    task automatic test_reset_midlock;
        do_reset();
        ack_p5 = 5'b00000;
        req_p5 = 5'b10010;
        step();
        checks++; if (g_p5 !== 5'b10000 || e_p5 !== 3'd4) begin errors++;
            $display("FAIL p5_lock got g=%b e=%0d want g=10000 e=4", g_p5, e_p5); end
        step();
        checks++; if (g_p5 !== 5'b10000) begin errors++;
            $display("FAIL p5_hold got g=%b want 10000", g_p5); end
        rst = 1'b1;
        step();
        checks++; if (g_p5 !== 5'b00000 || v_p5 !== 1'b0 || e_p5 !== 3'd0) begin errors++;
            $display("FAIL p5_midreset got g=%b v=%b e=%0d want g=00000 v=0 e=0", g_p5, v_p5, e_p5); end
        rst = 1'b0;
        step();
        checks++; if (g_p5 !== 5'b10000 || e_p5 !== 3'd4 || v_p5 !== 1'b1) begin errors++;
            $display("FAIL p5_reissue got g=%b e=%0d v=%b want g=10000 e=4 v=1", g_p5, e_p5, v_p5); end
        ack_p5 = 5'b10000;
        step();
        checks++; if (g_p5 !== 5'b00010 || e_p5 !== 3'd1) begin errors++;
            $display("FAIL p5_rotate got g=%b e=%0d want g=00010 e=1", g_p5, e_p5); end
        ack_p5 = 5'b00000;
        req_p5 = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            ack_p5 = g_p5;
            step();
            checks++; if (e_p5 > 3'd4 || (g_p5 !== (5'b00001 << e_p5))) begin errors++;
                $display("FAIL p5_encode cyc=%0d got g=%b e=%0d want one-hot matching e<=4",
                         i, g_p5, e_p5); end
        end
        ack_p5 = 5'b00000;
        req_p5 = 5'b00000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        zero4  = 4'b0000;
        rst    = 1'b1;
        req_rr = '0; req_rl = '0; req_fp = '0; req_ak = '0; ack_ak = '0;
        req_nk = '0; req_p5 = '0; ack_p5 = '0;
        #2;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_block_ack();
        test_block_noack();
        test_reset_midlock();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
